// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks with 0x80 + zero fill + 64-bit bit length.
// Optional feature macro SHA_PAD_LEN_CHK_EN: saturating byte count with sticky o_len_err.
module sha256_padder #(
    parameter int MAX_BYTES_W = 32
) (
    input  logic         usr_clk,
    input  logic         usr_reset_n,
    input  logic         i_valid,
    input  logic [7:0]   i_byte,
    input  logic         i_last,
    output logic         o_ready,
    output logic         o_blk_valid,
    output logic [511:0] o_blk,
    output logic         o_blk_last,
    input  logic         i_blk_ready,
    output logic         o_len_err
);

    typedef enum logic [1:0] {FILL, PAD, EMIT, LEN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_run;
    logic [5:0]             r_ptr;
    logic [MAX_BYTES_W-1:0] r_count;
    logic [511:0]           r_blk;
    logic                   r_blk_valid;
    logic                   r_blk_last;
    logic                   r_len_pend;
    logic                   r_pad_pend;

    logic                   w_accept;
    logic [63:0]            w_len;
    logic [511:0]           w_pad_blk;
    logic [511:0]           w_len_blk;
    logic [MAX_BYTES_W-1:0] w_count_nxt;

    // r_run keeps o_ready low until the first edge after reset release
    assign o_ready     = r_run & (r_state == FILL);
    assign w_accept    = i_valid & o_ready;
    assign o_blk       = r_blk;
    assign o_blk_valid = r_blk_valid;
    assign o_blk_last  = r_blk_last;

`ifdef SHA_PAD_LEN_CHK_EN
    logic r_len_err;
    logic w_len_err_set;

    always_comb begin
        w_len_err_set = 1'b0;
        w_count_nxt   = r_count + MAX_BYTES_W'(1);
        if (&r_count) begin
            w_count_nxt   = r_count;
            w_len_err_set = 1'b1;
        end
    end

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n)
            r_len_err <= 1'b0;
        else if (w_accept && w_len_err_set)
            r_len_err <= 1'b1;
    end

    assign o_len_err = r_len_err;
`else
    assign w_count_nxt = r_count + MAX_BYTES_W'(1);
    assign o_len_err   = 1'b0;
`endif

    always_comb begin
        w_len = '0;
        w_len[MAX_BYTES_W+2:0] = {r_count, 3'b000};
    end

    assign w_len_blk = {448'b0, w_len};

    // 0x80 at ptr, zeros after it; length only fits when ptr leaves bytes 56..63 free
    always_comb begin
        w_pad_blk = r_blk;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i == 32'(r_ptr))
                w_pad_blk[511-8*i -: 8] = 8'h80;
            else if (i > 32'(r_ptr))
                w_pad_blk[511-8*i -: 8] = 8'h00;
        end
        if (r_ptr <= 6'd55)
            w_pad_blk[63:0] = w_len;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: begin
                if (w_accept && (r_ptr == 6'd63))
                    w_state_nxt = EMIT;
                else if (w_accept && i_last)
                    w_state_nxt = PAD;
            end
            PAD:  w_state_nxt = EMIT;
            LEN:  w_state_nxt = EMIT;
            EMIT: begin
                if (i_blk_ready) begin
                    if (r_len_pend)
                        w_state_nxt = LEN;
                    else if (r_pad_pend)
                        w_state_nxt = PAD;
                    else
                        w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            r_state <= FILL;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_blk       <= '0;
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            r_len_pend  <= 1'b0;
            r_pad_pend  <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_blk[{~r_ptr, 3'b000} +: 8] <= i_byte;
                        r_count <= w_count_nxt;
                        r_ptr   <= r_ptr + 6'd1;
                        if (r_ptr == 6'd63) begin
                            r_blk_valid <= 1'b1;
                            r_blk_last  <= 1'b0;
                            r_pad_pend  <= i_last;
                        end
                    end
                end
                PAD: begin
                    r_blk       <= w_pad_blk;
                    r_blk_valid <= 1'b1;
                    r_blk_last  <= (r_ptr <= 6'd55);
                    r_len_pend  <= (r_ptr > 6'd55);
                    r_pad_pend  <= 1'b0;
                    r_ptr       <= '0;
                end
                LEN: begin
                    r_blk       <= w_len_blk;
                    r_blk_valid <= 1'b1;
                    r_blk_last  <= 1'b1;
                    r_len_pend  <= 1'b0;
                end
                EMIT: begin
                    if (i_blk_ready) begin
                        r_blk_valid <= 1'b0;
                        r_blk_last  <= 1'b0;
                        if (r_blk_last)
                            r_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: directed padding boundaries plus randomized traffic vs a queue-based model.
module tb_sha256_padder;

`ifdef SHA_PAD_LEN_CHK_EN
    localparam int MBW = 8;
`else
    localparam int MBW = 32;
`endif

    logic         usr_clk = 1'b0;
    logic         usr_reset_n = 1'b1;
    logic         i_valid = 1'b0;
    logic [7:0]   i_byte = 8'h00;
    logic         i_last = 1'b0;
    logic         i_blk_ready = 1'b0;
    logic         o_ready;
    logic         o_blk_valid;
    logic [511:0] o_blk;
    logic         o_blk_last;
    logic         o_len_err;

    sha256_padder #(.MAX_BYTES_W(MBW)) dut (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .i_valid     (i_valid),
        .i_byte      (i_byte),
        .i_last      (i_last),
        .o_ready     (o_ready),
        .o_blk_valid (o_blk_valid),
        .o_blk       (o_blk),
        .o_blk_last  (o_blk_last),
        .i_blk_ready (i_blk_ready),
        .o_len_err   (o_len_err)
    );

    always #5 usr_clk = ~usr_clk;

    int total = 0;
    int bad = 0;

    logic [7:0]   msg_q[$];
    logic [511:0] exp_q[$];
    logic [511:0] rx_q[$];
    bit           rx_last_q[$];
    bit           timed_out;

    // Reference: message || 0x80 || zeros to 56 mod 64 || 64-bit big-endian bit count
    function automatic void build_expected();
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] b;
        p = msg_q;
        bits = (64'(msg_q.size()) & ((64'd1 << MBW) - 64'd1)) << 3;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        exp_q.delete();
        for (int n = 0; n < p.size() / 64; n++) begin
            b = '0;
            for (int i = 0; i < 64; i++) b[511-8*i -: 8] = p[64*n + i];
            exp_q.push_back(b);
        end
    endfunction

    task automatic new_msg(input int n, input bit zero);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(zero ? 8'h00 : 8'($urandom));
        build_expected();
    endtask

    task automatic run_msg(input int gap_pct, input int hold_pct);
        int idx = 0;
        int cyc = 0;
        bit done = 0;
        rx_q.delete();
        rx_last_q.delete();
        timed_out = 0;
        while (!done && cyc < 3000) begin
            if (idx < msg_q.size() && $urandom_range(99) >= gap_pct) begin
                i_valid = 1'b1;
                i_byte  = msg_q[idx];
                i_last  = (idx == msg_q.size() - 1);
            end else begin
                i_valid = 1'b0;
                i_last  = 1'b0;
                i_byte  = 8'($urandom);
            end
            i_blk_ready = ($urandom_range(99) >= hold_pct);
            if (i_valid && o_ready) idx++;
            if (o_blk_valid && i_blk_ready) begin
                rx_q.push_back(o_blk);
                rx_last_q.push_back(o_blk_last);
                if (o_blk_last) done = 1;
            end
            @(posedge usr_clk); #1;
            cyc++;
        end
        i_valid = 1'b0;
        i_last = 1'b0;
        i_blk_ready = 1'b0;
        if (!done) timed_out = 1;
    endtask

    task automatic test_reset();
        #2 usr_reset_n = 1'b0;
        #1;
        total++;
        if ({o_ready, o_blk_valid, o_blk_last, o_len_err} !== 4'b0 || o_blk !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b v=%b l=%b e=%b blk_nz=%b want all 0",
                     o_ready, o_blk_valid, o_blk_last, o_len_err, |o_blk);
        end
        repeat (2) @(posedge usr_clk);
        #1 usr_reset_n = 1'b1;
        total++;
        if (o_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b want=0", o_ready); end
        @(posedge usr_clk); #1;
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%b want=1", o_ready); end
    endtask

    task automatic test_abc();
        logic [511:0] exp;
        logic [7:0]   abc [3];
        abc[0] = 8'h61; abc[1] = 8'h62; abc[2] = 8'h63;
        exp = '0;
        exp[511:480] = 32'h61626380;
        exp[7:0] = 8'h18;
        i_blk_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_byte = abc[i]; i_last = (i == 2);
            @(posedge usr_clk); #1;
        end
        i_valid = 1'b0; i_last = 1'b0;
        total++;
        if (o_blk_valid !== 1'b0 || o_ready !== 1'b0) begin
            bad++; $display("FAIL abc_pad_cycle got v=%b rdy=%b want v=0 rdy=0", o_blk_valid, o_ready);
        end
        @(posedge usr_clk); #1;
        total++;
        if (o_blk_valid !== 1'b1 || o_blk_last !== 1'b1 || o_blk !== exp) begin
            bad++; $display("FAIL abc_block got v=%b l=%b blk=%h want v=1 l=1 blk=%h", o_blk_valid, o_blk_last, o_blk, exp);
        end
        i_blk_ready = 1'b1;
        @(posedge usr_clk); #1;
        i_blk_ready = 1'b0;
        total++;
        if (o_blk_valid !== 1'b0 || o_ready !== 1'b1) begin
            bad++; $display("FAIL abc_after_hs got v=%b rdy=%b want v=0 rdy=1", o_blk_valid, o_ready);
        end
    endtask

    task automatic test_boundaries();
        int lens [6] = '{55, 56, 63, 64, 119, 128};
        for (int t = 0; t < 6; t++) begin
            new_msg(lens[t], lens[t] == 55);
            run_msg(0, 0);
            total++;
            if (timed_out || rx_q.size() != exp_q.size()) begin
                bad++; $display("FAIL bnd_count len=%0d got=%0d want=%0d to=%b", lens[t], rx_q.size(), exp_q.size(), timed_out);
            end
            for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (rx_q[i] !== exp_q[i] || rx_last_q[i] !== (i == exp_q.size() - 1)) begin
                    bad++; $display("FAIL bnd_block len=%0d idx=%0d got l=%b %h want %h", lens[t], i, rx_last_q[i], rx_q[i], exp_q[i]);
                end
            end
            total++;
            case (lens[t])
                55: if (rx_q.size() != 1 || rx_q[0][71:64] !== 8'h80 || rx_q[0][63:0] !== 64'h1B8) begin
                        bad++; $display("FAIL bnd55 got n=%0d blk=%h want 0x80@55 len=1b8", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : '0);
                    end
                56: if (rx_q.size() != 2 || rx_q[0][63:56] !== 8'h80 || rx_last_q[0] !== 1'b0 || rx_q[1] !== {448'b0, 64'h1C0}) begin
                        bad++; $display("FAIL bnd56 got n=%0d want 0x80@56 then len=1c0", rx_q.size());
                    end
                64: if (rx_q.size() != 2 || rx_q[1][511:504] !== 8'h80 || rx_q[1][63:0] !== 64'h200 || rx_last_q[1] !== 1'b1) begin
                        bad++; $display("FAIL bnd64 got n=%0d want 0x80@0 len=200 last", rx_q.size());
                    end
                default: if (o_ready !== 1'b1) begin
                        bad++; $display("FAIL next_msg_ready len=%0d got=%b want=1", lens[t], o_ready);
                    end
            endcase
        end
    endtask

    task automatic test_stall();
        logic [511:0] cap;
        int guard = 0;
        new_msg(20, 0);
        i_blk_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            i_valid = 1'b1; i_byte = msg_q[i]; i_last = (i == 19);
            @(posedge usr_clk); #1;
        end
        i_valid = 1'b0; i_last = 1'b0;
        while (!o_blk_valid && guard < 10) begin @(posedge usr_clk); #1; guard++; end
        cap = o_blk;
        total++;
        if (o_blk_valid !== 1'b1 || cap !== exp_q[0] || o_blk_last !== 1'b1) begin
            bad++; $display("FAIL stall_block got v=%b l=%b %h want %h", o_blk_valid, o_blk_last, cap, exp_q[0]);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge usr_clk); #1;
            total++;
            if (o_blk !== cap || o_blk_valid !== 1'b1 || o_blk_last !== 1'b1 || o_ready !== 1'b0) begin
                bad++; $display("FAIL stall_hold cyc=%0d got v=%b l=%b rdy=%b stable=%b want v=1 l=1 rdy=0 stable=1",
                                c, o_blk_valid, o_blk_last, o_ready, o_blk === cap);
            end
        end
        i_blk_ready = 1'b1;
        @(posedge usr_clk); #1;
        i_blk_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 64; i++) begin
            i_valid = 1'b1; i_byte = 8'($urandom); i_last = 1'b0;
            @(posedge usr_clk); #1;
        end
        i_valid = 1'b0;
        usr_reset_n = 1'b0;
        #1;
        total++;
        if (o_blk_valid !== 1'b0 || o_blk !== '0 || o_ready !== 1'b0 || o_blk_last !== 1'b0) begin
            bad++; $display("FAIL reset_mid got v=%b rdy=%b l=%b blk_nz=%b want all 0", o_blk_valid, o_ready, o_blk_last, |o_blk);
        end
        @(posedge usr_clk); #1;
        usr_reset_n = 1'b1;
        @(posedge usr_clk); #1;
        new_msg(40, 0);
        run_msg(20, 20);
        total++;
        if (timed_out || rx_q.size() != 1 || rx_q[0] !== exp_q[0] || rx_last_q[0] !== 1'b1) begin
            bad++; $display("FAIL reset_next_msg got n=%0d to=%b blk=%h want %h", rx_q.size(), timed_out,
                            rx_q.size() > 0 ? rx_q[0] : '0, exp_q[0]);
        end
    endtask

    task automatic test_random();
        int n;
        for (int m = 0; m < 20; m++) begin
            n = $urandom_range(140, 1);
            new_msg(n, 0);
            run_msg(30, 40);
            total++;
            if (timed_out || rx_q.size() != exp_q.size()) begin
                bad++; $display("FAIL rnd_count len=%0d got=%0d want=%0d to=%b", n, rx_q.size(), exp_q.size(), timed_out);
            end
            for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (rx_q[i] !== exp_q[i] || rx_last_q[i] !== (i == exp_q.size() - 1)) begin
                    bad++; $display("FAIL rnd_block len=%0d idx=%0d got l=%b %h want %h", n, i, rx_last_q[i], rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_len_err();
`ifdef SHA_PAD_LEN_CHK_EN
        int guard;
        i_blk_ready = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            guard = 0;
            while (!o_ready && guard < 10) begin @(posedge usr_clk); #1; guard++; end
            i_valid = 1'b1; i_byte = 8'($urandom); i_last = (k == 256);
            @(posedge usr_clk); #1;
            i_valid = 1'b0; i_last = 1'b0;
            if (k == 255) begin
                total++;
                if (o_len_err !== 1'b0) begin bad++; $display("FAIL len_err_255 got=%b want=0", o_len_err); end
            end
            if (k == 256) begin
                total++;
                if (o_len_err !== 1'b1) begin bad++; $display("FAIL len_err_256 got=%b want=1", o_len_err); end
            end
        end
        repeat (20) @(posedge usr_clk);
        #1;
        i_blk_ready = 1'b0;
        total++;
        if (o_len_err !== 1'b1 || o_ready !== 1'b1) begin
            bad++; $display("FAIL len_err_sticky got err=%b rdy=%b want err=1 rdy=1", o_len_err, o_ready);
        end
        usr_reset_n = 1'b0;
        #1;
        total++;
        if (o_len_err !== 1'b0) begin bad++; $display("FAIL len_err_reset got=%b want=0", o_len_err); end
        @(posedge usr_clk); #1;
        usr_reset_n = 1'b1;
        @(posedge usr_clk); #1;
`else
        new_msg(70, 0);
        run_msg(0, 0);
        total++;
        if (o_len_err !== 1'b0 || timed_out) begin
            bad++; $display("FAIL len_err_tied got=%b to=%b want=0", o_len_err, timed_out);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_abc();
        test_boundaries();
        test_stall();
        test_reset_mid();
        test_random();
        test_len_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter MAX_BYTES_W, default 32, byte-counter width; legal range 8..61.
REQ-002 SHALL have port usr_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port usr_reset_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port i_valid, input, 1, the byte on i_byte is offered.
REQ-005 SHALL have port i_byte, input, 8, message byte, in message order.
REQ-006 SHALL have port i_last, input, 1, the offered byte is the final byte of the message.
REQ-007 SHALL have port o_ready, output, 1, a byte is accepted on a cycle where i_valid and o_ready are both high.
REQ-008 SHALL have port o_blk_valid, output, 1, o_blk holds a complete 512-bit block.
REQ-009 SHALL have port o_blk, output, 512, padded block; first message byte in bits [511:504].
REQ-010 SHALL have port o_blk_last, output, 1, qualifies o_blk_valid; this is the final block of the message.
REQ-011 SHALL have port i_blk_ready, input, 1, the hash core has taken the block.
REQ-012 SHALL have port o_len_err, output, 1, byte-count overflow flag (present only per REQ-027).

Function
REQ-013 SHALL implement states FILL, PAD, EMIT, LEN; FILL is the only state in which o_ready is high.
REQ-014 SHALL, in FILL, write each accepted byte at pointer ptr (0..63), increment ptr, and increment the byte count.
REQ-015 SHALL, on accepting a non-last byte at ptr=63, go to EMIT with o_blk_last=0; o_blk_valid goes high the next cycle.
REQ-016 SHALL, on accepting a last byte at ptr<=62, go to PAD; PAD lasts exactly one cycle, then EMIT (o_blk_valid 2 cycles after the last-byte edge).
REQ-017 SHALL, on accepting a last byte at ptr=63, emit the data block with o_blk_last=0, then go to PAD with ptr=0.
REQ-018 SHALL, in PAD, write 0x80 at ptr and zero all later bytes; if ptr<=55, write the length into bytes 56..63 and set o_blk_last=1; otherwise set o_blk_last=0 and mark a pending length block.
REQ-019 SHALL encode the length as a 64-bit big-endian value equal to the byte count x 8, zero-extended.
REQ-020 SHALL, in EMIT, hold o_blk, o_blk_valid and o_blk_last stable until i_blk_ready is high; on that edge drop o_blk_valid.
REQ-021 SHALL, after the EMIT handshake: go to LEN if a length block is pending; go to PAD if marked per REQ-017; otherwise go to FILL with ptr=0 (byte count cleared after a last block).
REQ-022 SHALL, in LEN, build a block that is all zero except bytes 56..63 (the length), then go to EMIT with o_blk_last=1.
REQ-023 SHALL treat every message as at least 1 byte long; zero-length messages are not supported.
REQ-024 SHALL accept the first byte of the next message in the cycle after the final-block handshake.

Reset
REQ-025 SHALL, while usr_reset_n is low, immediately force state=FILL, ptr=0, count=0, o_blk=0, o_blk_valid=0, o_blk_last=0, o_len_err=0, o_ready=0; o_ready rises on the first clock edge after release.
REQ-026 SHALL abandon any partially filled or un-handshaken block on reset; no block is emitted.

Configuration
REQ-027 SHALL support macro SHA_PAD_LEN_CHK_EN. When defined: o_len_err sets and stays high when the count would exceed 2^MAX_BYTES_W-1; the count saturates; the flag clears only on reset. When undefined: o_len_err is tied to 0 and the count wraps modulo 2^MAX_BYTES_W.

Verification
REQ-028 SHALL cover: "abc" (61,62,63, last on 63) -> one block 0x6162638000...0018, o_blk_last=1, o_blk_valid 2 cycles after the last byte.
REQ-029 SHALL cover: 55 bytes of 0x00 -> one block with 0x80 at byte 55 and length 0x1B8, o_blk_last=1.
REQ-030 SHALL cover: 56 bytes -> block 1 with 0x80 at byte 56, o_blk_last=0; then block 2 all zero with length 0x1C0, o_blk_last=1.
REQ-031 SHALL cover: 64 bytes -> data block (last=0), then 0x80 followed by zeros and length 0x200 (last=1).
REQ-032 SHALL cover: i_blk_ready held low for 10 cycles -> o_blk stable, o_ready=0 throughout; reset asserted mid-message -> outputs 0 in the same cycle and the next message is padded correctly.
REQ-033 SHALL cover, with SHA_PAD_LEN_CHK_EN and MAX_BYTES_W=8: 256 bytes -> o_len_err=1 after byte 256 and stays high until reset.
